// File: rtl/ctrl_pkt_gen.sv
// Control-path packet initiator: queues table-entry write requests and emits
// each as a 2-beat AXI-Stream control packet (header, then payload).
module ctrl_pkt_gen #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ENTRY_W              = 256,
  parameter int NUM_STAGES           = 5,
  parameter int FIFO_DEPTH           = 4,
  parameter int GAP_CYCLES           = 2
) (
  input  logic                                axis_clk,
  input  logic                                areset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [4:0]                          req_stage,
  input  logic [2:0]                          req_module,
  input  logic [7:0]                          req_addr,
  input  logic [ENTRY_W-1:0]                  req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
  output logic                                c_m_axis_tvalid,
  output logic                                c_m_axis_tlast,
  input  logic                                c_m_axis_tready,
  output logic                                busy,
  output logic                                err_drop,
  output logic [31:0]                         pkt_cnt
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [5:0]    NS        = 6'(NUM_STAGES);
  localparam logic [UW-1:0] TUSER_PKT = UW'(128);

  typedef struct packed {
    logic [4:0]         stage;
    logic [2:0]         mod;
    logic [7:0]         addr;
    logic [ENTRY_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  req_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           push, pop, legal;
  req_t           head;

  state_t             state;
  logic [ENTRY_W-1:0] cur_data;
  logic [15:0]        seq;
  logic [GW-1:0]      gap_cnt;

  function automatic logic [DW-1:0] mk_hdr(input req_t r, input logic [15:0] s);
    logic [DW-1:0] h;
    h        = '0;
    h[15:0]  = 16'hF1F2;
    h[20:16] = r.stage;
    h[23:21] = r.mod;
    h[31:24] = r.addr;
    h[47:32] = s;
    return h;
  endfunction

  assign head    = mem[rd_ptr];
  assign push    = req_valid & req_ready;
  assign pop     = (state == IDLE) && (cnt != '0);
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign legal   = ({1'b0, head.stage} < NS) && (head.mod <= 3'd2);

  always_ff @(posedge axis_clk)
    if (push) mem[wr_ptr] <= '{req_stage, req_module, req_addr, req_data};

  // req_ready is registered from the next occupancy so it never lags a push
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt       <= cnt_nxt;
      req_ready <= (cnt_nxt != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state           <= IDLE;
      cur_data        <= '0;
      seq             <= '0;
      gap_cnt         <= '0;
      pkt_cnt         <= '0;
      busy            <= 1'b0;
      err_drop        <= 1'b0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
    end else begin
      err_drop <= 1'b0;
      case (state)
        IDLE: begin
          busy <= (cnt_nxt != '0);
          if (pop) begin
            if (legal) begin
              cur_data        <= head.data;
              state           <= HDR;
              busy            <= 1'b1;
              c_m_axis_tvalid <= 1'b1;
              c_m_axis_tlast  <= 1'b0;
              c_m_axis_tkeep  <= '1;
              c_m_axis_tuser  <= TUSER_PKT;
              c_m_axis_tdata  <= mk_hdr(head, seq);
            end else begin
              err_drop <= 1'b1;
            end
          end
        end
        HDR: if (c_m_axis_tready) begin
          state          <= PAY;
          c_m_axis_tlast <= 1'b1;
          c_m_axis_tdata <= DW'(cur_data);
        end
        PAY: if (c_m_axis_tready) begin
          seq             <= seq + 16'd1;
          pkt_cnt         <= pkt_cnt + 32'd1;
          c_m_axis_tvalid <= 1'b0;
          c_m_axis_tlast  <= 1'b0;
          c_m_axis_tdata  <= '0;
          c_m_axis_tuser  <= '0;
          c_m_axis_tkeep  <= '0;
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GW'(GAP_CYCLES - 1);
          end else begin
            state <= IDLE;
            busy  <= (cnt_nxt != '0);
          end
        end
        GAP: begin
          // GAP plus the IDLE pop cycle gives 1 + GAP_CYCLES idle beats
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= (cnt_nxt != '0);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
